// File: rtl/mul_div_unit.sv
// Iterative WIDTH-bit multiply/divide unit: shift-add multiply, restoring divide, sign fix-up.
// Latency: Done is shown WIDTH+1 edges after the Start edge, or 1 edge for divide-by-zero.
//   With MULDIV_EARLY_OUT_EN, a multiply takes (msb index of |B|)+2 edges.
// Backpressure: Start is sampled only in IDLE and is ignored while Busy; there is no queuing.
// Ports: clk, reset (async active-low), Start/Div/Unsigned/A/B request, Busy (state != IDLE),
//   Done (1-cycle pulse), ResultLo (product low / quotient), ResultHi (product high / remainder),
//   DivZero (divide with B == 0). Results hold until the next FIX.
// Optional feature macro: MULDIV_EARLY_OUT_EN (multiply ends once the remaining |B| is zero).
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Div,
  input  logic             Unsigned,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic               div_q;      // latched operation select
  logic               dz_q;       // divide with zero divisor
  logic               res_neg_q;  // product/quotient must be negated
  logic               rem_neg_q;  // remainder follows the dividend sign
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;       // multiply accumulator
  logic [2*WIDTH-1:0] mcand;      // |A| shifted left each multiply step
  logic [WIDTH-1:0]   opb;        // |B|: shifted right for multiply, fixed divisor for divide
  logic [WIDTH-1:0]   quo;        // |A| shifting out MSB-first, quotient bits shifting in
  logic [WIDTH-1:0]   rem;

  // Operand magnitudes; -A of the most negative value is itself, which is the correct magnitude.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = !Unsigned && A[WIDTH-1];
  assign b_neg = !Unsigned && B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // Restoring divide step. rem < divisor, so the shifted value needs only one extra bit and
  // the difference (taken only when non-negative) fits back into WIDTH bits.
  logic [WIDTH:0]   shifted;
  logic             q_bit;
  logic [WIDTH-1:0] diff;

  assign shifted = {rem, quo[WIDTH-1]};
  assign q_bit   = shifted >= {1'b0, opb};
  assign diff    = shifted[WIDTH-1:0] - opb;

  logic calc_last;
`ifdef MULDIV_EARLY_OUT_EN
  // Multiply stops after the step that consumes the last set bit of |B| (at least one step).
  assign calc_last = (cnt == CW'(WIDTH - 1)) || (!div_q && (opb[WIDTH-1:1] == '0));
`else
  assign calc_last = (cnt == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = (Div && (B == '0)) ? FIX : CALC;
        end
      end
      CALC: begin
        if (calc_last) begin
          state_nxt = FIX;
        end
      end
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt       <= '0;
      prod      <= '0;
      mcand     <= '0;
      opb       <= '0;
      quo       <= '0;
      rem       <= '0;
      ResultLo  <= '0;
      ResultHi  <= '0;
      DivZero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            div_q     <= Div;
            dz_q      <= Div && (B == '0);
            res_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            cnt       <= '0;
            prod      <= '0;
            mcand     <= {{WIDTH{1'b0}}, a_mag};
            opb       <= b_mag;
            quo       <= a_mag;
            rem       <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (div_q) begin
            quo <= {quo[WIDTH-2:0], q_bit};
            rem <= q_bit ? diff : shifted[WIDTH-1:0];
          end else begin
            if (opb[0]) begin
              prod <= prod + mcand;
            end
            mcand <= mcand << 1;
            opb   <= opb >> 1;
          end
        end
        FIX: begin
          if (!div_q) begin
            {ResultHi, ResultLo} <= res_neg_q ? -prod : prod;
            DivZero              <= 1'b0;
          end else if (dz_q) begin
            // quo still holds |A|; re-applying the dividend sign returns A unmodified.
            ResultLo <= '1;
            ResultHi <= rem_neg_q ? -quo : quo;
            DivZero  <= 1'b1;
          end else begin
            ResultLo <= res_neg_q ? -quo : quo;
            ResultHi <= rem_neg_q ? -rem : rem;
            DivZero  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk      = 1'b0;
  logic         reset    = 1'b0;
  logic         Start    = 1'b0;
  logic         Div      = 1'b0;
  logic         Unsigned = 1'b0;
  logic [W-1:0] A        = '0;
  logic [W-1:0] B        = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] ResultLo;
  logic [W-1:0] ResultHi;
  logic         DivZero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t scb[$];

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .Div      (Div),
    .Unsigned (Unsigned),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Done     (Done),
    .ResultLo (ResultLo),
    .ResultHi (ResultHi),
    .DivZero  (DivZero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: wide-integer arithmetic; lat = edges from accept to Done visible.
  function automatic exp_t model(input logic d, input logic u, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t               e;
    logic [63:0]        p;
    logic signed [63:0] sa, sbv, sq, sr;
    int                 k;
`ifdef MULDIV_EARLY_OUT_EN
    logic [W-1:0]       bm;
`endif
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    if (!d) begin
      if (u) p = {32'b0, a} * {32'b0, b};
      else   p = sa * sbv;
      e.lo = p[31:0];
      e.hi = p[63:32];
      e.dz = 1'b0;
      k    = W;
`ifdef MULDIV_EARLY_OUT_EN
      bm = (!u && b[31]) ? -b : b;
      k  = 1;
      for (int i = 0; i < W; i++) if (bm[i]) k = i + 1;
`endif
      e.lat = k + 1;
    end else if (b == '0) begin
      e.lo  = '1;
      e.hi  = a;
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      if (u) begin
        e.lo = a / b;
        e.hi = a % b;
      end else begin
        sq   = sa / sbv;
        sr   = sa % sbv;
        e.lo = sq[31:0];
        e.hi = sr[31:0];
      end
      e.dz  = 1'b0;
      e.lat = W + 1;
    end
    return e;
  endfunction

  // Drives one operation; poke>0 pulses Start with junk operands that many edges after accept.
  task automatic run_op(input string tag, input logic d, input logic u, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int poke);
    exp_t e;
    int   lat;
    bit   seen;
    scb.push_back(model(d, u, a, b));
    @(negedge clk);
    Start = 1'b1; Div = d; Unsigned = u; A = a; B = b;
    @(negedge clk);  // accept edge N has passed
    Start = 1'b0; Div = ~d; A = $urandom; B = $urandom;
    chk({tag, ".busy_rise"}, 64'(Busy), 64'(1));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == poke) begin
        Start = 1'b1; A = $urandom; B = $urandom;
      end else begin
        Start = 1'b0;
      end
      seen = Done;
    end
    Start = 1'b0;
    e = scb.pop_front();
    chk({tag, ".latency"}, 64'(lat), 64'(e.lat));
    chk({tag, ".lo"}, 64'(ResultLo), 64'(e.lo));
    chk({tag, ".hi"}, 64'(ResultHi), 64'(e.hi));
    chk({tag, ".divzero"}, 64'(DivZero), 64'(e.dz));
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(Done), 64'(0));
    chk({tag, ".busy_fall"}, 64'(Busy), 64'(0));
    chk({tag, ".hold_lo"}, 64'(ResultLo), 64'(e.lo));
  endtask

  initial begin
    bit seen;

    #12;
    chk("reset.busy", 64'(Busy), 64'(0));
    chk("reset.done", 64'(Done), 64'(0));
    chk("reset.lo", 64'(ResultLo), 64'(0));
    chk("reset.hi", 64'(ResultHi), 64'(0));
    chk("reset.divzero", 64'(DivZero), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    run_op("umul_max", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("smul_neg", 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7, 0);
    run_op("sdiv_neg", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divzero", 1'b1, 1'b0, 32'd5, 32'd0, 0);
    run_op("sdiv_wrap", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("udiv", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd3, 0);
    run_op("divzero_neg", 1'b1, 1'b0, 32'h8000_0001, 32'd0, 0);
    run_op("smul_minneg", 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mul_b0", 1'b0, 1'b1, 32'h1234_5678, 32'd0, 0);
    run_op("mul_5x2", 1'b0, 1'b1, 32'd5, 32'd2, 0);
    run_op("sdiv_negdivisor", 1'b1, 1'b0, 32'd100, 32'hFFFF_FFF9, 0);
    run_op("start_reject", 1'b0, 1'b0, 32'd1234, 32'hFFFF_FFFB, 10);

    for (int i = 0; i < 6; i++) begin
      run_op("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             32'($urandom), 32'($urandom), 0);
    end

    // Known non-zero result sits in the output registers before the mid-CALC reset.
    run_op("pre_reset", 1'b0, 1'b1, 32'h0001_0001, 32'h0000_FFFF, 0);
    @(negedge clk);
    Start = 1'b1; Div = 1'b0; Unsigned = 1'b1; A = 32'h1234_5678; B = 32'hFFFF_FFFF;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset.busy", 64'(Busy), 64'(0));
    chk("midreset.done", 64'(Done), 64'(0));
    chk("midreset.lo", 64'(ResultLo), 64'(0));
    chk("midreset.hi", 64'(ResultHi), 64'(0));
    chk("midreset.divzero", 64'(DivZero), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (Done) seen = 1'b1;
    end
    chk("midreset.no_done", 64'(seen), 64'(0));
    chk("midreset.idle", 64'(Busy), 64'(0));

    run_op("post_reset", 1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide execution unit, directly downstream of the instruction decoder. It consumes the decoder's multiply/divide operation selection, signedness and long-result controls, plus the two register operands. It produces a 64-bit product, or a quotient/remainder pair, after a multi-cycle computation. A Start/Busy/Done handshake lets the controller stall the pipeline while the unit runs.

## Interface
Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Div  input  1  operation select: 0 = multiply, 1 = divide.
- Unsigned  input  1  1 = unsigned operands, 0 = two's-complement operands.
- A  input  WIDTH  multiplicand or dividend.
- B  input  WIDTH  multiplier or divisor.
- Busy  output  1  high whenever the state is not IDLE.
- Done  output  1  one-cycle pulse when the result is valid.
- ResultLo  output  WIDTH  low product half, or quotient.
- ResultHi  output  WIDTH  high product half, or remainder.
- DivZero  output  1  set with Done when a divide had B == 0.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE**
  - Start=1 latches Div, Unsigned, A and B.
  - When signed, operands are converted to magnitudes and the result sign is recorded.
  - Next state is CALC, with the iteration counter cleared.
  - Exception: a divide with B==0 goes directly to FIX.
- **CALC, multiply**
  - Shift-add, one multiplier bit per cycle, LSB first, on |B|.
  - Accumulates into a 2*WIDTH product register.
- **CALC, divide**
  - Restoring division, one quotient bit per cycle, MSB first.
  - Produces a WIDTH-bit quotient and remainder.
- **CALC exit:** leave to FIX after WIDTH iterations. With MULDIV_EARLY_OUT_EN, a multiply may exit earlier (see Configuration).
- **FIX** applies signs and writes the result registers:
  - Product is negated when the operand signs differed.
  - Quotient is negated when the operand signs differed.
  - Remainder takes the sign of the dividend.
- **Signed edge case:** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This is the natural wrap and is not flagged.
- **Divide by zero:** quotient = all ones, remainder = A (unmodified), DivZero=1.
- **DONE:** Done=1 for one cycle, then the state returns to IDLE.
- **Start handling:**
  - Start is ignored in CALC, FIX and DONE; there is no queuing.
  - The controller must hold operands only on the accepting edge.
- **Result hold:**
  - ResultLo, ResultHi and DivZero hold their values until the next FIX writes them.
  - DivZero is cleared in FIX for non-zero divides.
- **Reset:** active asynchronously at any time, including mid-CALC. Forces IDLE and clears all outputs and internal registers to 0. The interrupted operation is lost, with no Done.

## Timing
- Reset values: Busy=0, Done=0, ResultLo=0, ResultHi=0, DivZero=0.
- Start accepted at edge N:
  - Busy=1 from after edge N.
  - Iterations occur at edges N+1 … N+k.
  - FIX occupies edge N+k+1; results and Done are visible after that edge.
  - Busy falls after edge N+k+2.
- Fixed latency: k=WIDTH, so Done appears after edge N+33 (WIDTH=32).
- Divide by zero: Done appears after edge N+1.
- Back-to-back: the earliest next accept is the edge after Done falls (IDLE).

## Configuration
- **MULDIV_EARLY_OUT_EN defined**
  - Multiply CALC ends after the iteration in which the remaining shifted |B| becomes zero.
  - Minimum one iteration; k = index of highest set bit of |B| + 1, or k=1 when B==0.
  - Divide is unaffected.
- **Not defined:** every multiply and divide takes exactly WIDTH iterations.

## Test plan
- **Unsigned multiply:** Unsigned=1, Div=0, A=B=0xFFFFFFFF
  - ResultHi=0xFFFFFFFE, ResultLo=0x00000001.
  - Done after edge N+33 when MULDIV_EARLY_OUT_EN is undefined.
- **Signed multiply:** A=0xFFFFFFFD (-3), B=7
  - ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFEB.
- **Signed divide:** A=0xFFFFFFF9 (-7), B=2
  - ResultLo=0xFFFFFFFD, ResultHi=0xFFFFFFFF, DivZero=0.
- **Divide by zero:** A=5, B=0, Div=1
  - Done after edge N+1, ResultLo=0xFFFFFFFF, ResultHi=5, DivZero=1.
- **Reset and Start rejection:**
  - Drop reset at cycle 10 of CALC → all outputs 0 immediately, no Done.
  - Start pulsed while Busy → ignored; the running result is unchanged.
- **Early-out, MULDIV_EARLY_OUT_EN defined:**
  - A=5, B=2 → k=2, Done after edge N+3, ResultLo=10.
  - B=0 → Done after edge N+2, result 0.
